// File: rtl/cute_pkg.sv
// cute_pkg: shared data width, register count and FSM encoding for reg_demux
package cute_pkg;
  localparam int DATA_W = 9;
  localparam int NUM_REGS = 10;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/reg_demux.sv
// reg_demux: captures din/dst on wr_req, writes din into q[dst] next edge, pulses wr_ack, counts writes, flags bad dst
module reg_demux
  import cute_pkg::*;
#(
  parameter int DATA_W = cute_pkg::DATA_W,
  parameter int NUM_REGS = cute_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        dst,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic              busy,
  output logic              err,
  output logic [7:0]        wr_cnt,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] q4,
  output logic [DATA_W-1:0] q5,
  output logic [DATA_W-1:0] q6,
  output logic [DATA_W-1:0] q7,
  output logic [DATA_W-1:0] q8,
  output logic [DATA_W-1:0] q9
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        dst_q, dst_d;
  logic [DATA_W-1:0] q_q [10];
  logic [DATA_W-1:0] q_d [10];
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid;
  assign valid = 32'(dst_q) < NUM_REGS;
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    dst_d   = dst_q;
    q_d     = q_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = LOAD;
          din_d   = din;
          dst_d   = dst;
        end
      end
      LOAD: begin
        state_d = DONE;
        err_d   = !valid;
        cnt_d   = valid ? cnt_q + 8'd1 : cnt_q;
        if (valid) begin
          case (dst_q)
            4'd0: q_d[0] = din_q;
            4'd1: q_d[1] = din_q;
            4'd2: q_d[2] = din_q;
            4'd3: q_d[3] = din_q;
            4'd4: q_d[4] = din_q;
            4'd5: q_d[5] = din_q;
            4'd6: q_d[6] = din_q;
            4'd7: q_d[7] = din_q;
            4'd8: q_d[8] = din_q;
            4'd9: q_d[9] = din_q;
            default: ;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 10; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end
  assign wr_ack = state_q == DONE;
  assign busy   = state_q != IDLE;
  assign err    = err_q;
  assign wr_cnt = cnt_q;
  assign q0 = q_q[0];
  assign q1 = q_q[1];
  assign q2 = q_q[2];
  assign q3 = q_q[3];
  assign q4 = q_q[4];
  assign q5 = q_q[5];
  assign q6 = q_q[6];
  assign q7 = q_q[7];
  assign q8 = q_q[8];
  assign q9 = q_q[9];
endmodule

// File: tb/tb_reg_demux.sv
// tb_reg_demux: scoreboard bench for reg_demux
module tb_reg_demux;
  logic       clk = 0, rst = 1, wr_req = 0;
  logic [8:0] din = 0;
  logic [3:0] dst = 0;
  logic       wr_ack, busy, err;
  logic [7:0] wr_cnt;
  logic [8:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9;
  logic [89:0] qv;
  typedef struct packed {
    logic [3:0]  dst;
    logic [8:0]  din;
    logic        err;
    logic [7:0]  cnt;
    logic [89:0] q;
  } exp_t;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [8:0] m_q [10];
  logic [7:0] m_cnt;
  logic       m_err;
  int         n_cmp = 0, n_bad = 0;

  reg_demux dut (
    .clk(clk), .rst(rst), .din(din), .dst(dst), .wr_req(wr_req),
    .wr_ack(wr_ack), .busy(busy), .err(err), .wr_cnt(wr_cnt),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4),
    .q5(q5), .q6(q6), .q7(q7), .q8(q8), .q9(q9)
  );

  always #5 clk = ~clk;
  assign qv = {q9, q8, q7, q6, q5, q4, q3, q2, q1, q0};

  function automatic logic [89:0] m_pack();
    logic [89:0] r;
    for (int i = 0; i < 10; i++) r[i*9 +: 9] = m_q[i];
    return r;
  endfunction

  task automatic model_req(input logic [3:0] d, input logic [8:0] v);
    exp_t e;
    if (d < 10) begin
      m_q[d] = v;
      m_cnt++;
      m_err = 0;
    end else m_err = 1;
    e.dst = d; e.din = v; e.err = m_err; e.cnt = m_cnt; e.q = m_pack();
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 10; i++) m_q[i] = '0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    wr_req = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && wr_ack) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_unexpected: wr_ack=1 with no pending request at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        n_cmp += 3;
        if (qv !== mon_e.q) begin n_bad++; $display("FAIL sb_q dst=%0d: got %h want %h", mon_e.dst, qv, mon_e.q); end
        if (err !== mon_e.err) begin n_bad++; $display("FAIL sb_err dst=%0d: got %b want %b", mon_e.dst, err, mon_e.err); end
        if (wr_cnt !== mon_e.cnt) begin n_bad++; $display("FAIL sb_cnt dst=%0d: got %0d want %0d", mon_e.dst, wr_cnt, mon_e.cnt); end
      end
    end
  end

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    n_cmp += 3;
    if (qv !== '0) begin n_bad++; $display("FAIL reset_q: got %h want 0", qv); end
    if (wr_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", wr_cnt); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_single();
    @(negedge clk);
    wr_req = 1; din = 9'h1A5; dst = 3;
    model_req(3, 9'h1A5);
    @(negedge clk);
    wr_req = 0; din = 9'h0AA; dst = 5;
    n_cmp += 3;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_load: got %b want 1", busy); end
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_load: got %b want 0", wr_ack); end
    if (q3 !== 9'h000) begin n_bad++; $display("FAIL single_q3_early: got %h want 000", q3); end
    @(negedge clk);
    n_cmp += 3;
    if (q3 !== 9'h1A5) begin n_bad++; $display("FAIL single_q3: got %h want 1a5", q3); end
    if (q5 !== 9'h000) begin n_bad++; $display("FAIL single_q5: got %h want 000", q5); end
    if (wr_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack: got %b want 1", wr_ack); end
    @(negedge clk);
    n_cmp += 3;
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_end: got %b want 0", wr_ack); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (wr_cnt !== 8'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    wr_req = 1; din = 9'h0FF; dst = 12;
    model_req(12, 9'h0FF);
    @(negedge clk);
    wr_req = 0;
    repeat (2) @(negedge clk);
    n_cmp += 3;
    if (err !== 1'b1) begin n_bad++; $display("FAIL invalid_err: got %b want 1", err); end
    if (wr_cnt !== 8'd1) begin n_bad++; $display("FAIL invalid_cnt: got %0d want 1", wr_cnt); end
    if (qv !== m_pack()) begin n_bad++; $display("FAIL invalid_q: got %h want %h", qv, m_pack()); end
    @(negedge clk);
    wr_req = 1; din = 9'h001; dst = 0;
    model_req(0, 9'h001);
    @(negedge clk);
    wr_req = 0;
    repeat (2) @(negedge clk);
    n_cmp += 3;
    if (q0 !== 9'h001) begin n_bad++; $display("FAIL recover_q0: got %h want 001", q0); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL recover_err: got %b want 0", err); end
    if (wr_cnt !== 8'd2) begin n_bad++; $display("FAIL recover_cnt: got %0d want 2", wr_cnt); end
  endtask

  task automatic test_all_regs();
    logic [89:0] want;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_req = 1; dst = 4'(k); din = 9'h100 + 9'(k);
      model_req(4'(k), 9'h100 + 9'(k));
      @(negedge clk);
      wr_req = 0;
      @(negedge clk);
    end
    @(negedge clk);
    for (int k = 0; k < 10; k++) want[k*9 +: 9] = 9'h100 + 9'(k);
    n_cmp += 2;
    if (qv !== want) begin n_bad++; $display("FAIL all_regs_q: got %h want %h", qv, want); end
    if (wr_cnt !== 8'd10) begin n_bad++; $display("FAIL all_regs_cnt: got %0d want 10", wr_cnt); end
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge clk);
    wr_req = 1; dst = 9; din = 9'h1FF;
    @(negedge clk);
    wr_req = 0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
    #2 rst = 1;
    #1;
    n_cmp += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_async: got %b want 0", busy); end
    if (q9 !== 9'h000) begin n_bad++; $display("FAIL abort_q9_async: got %h want 000", q9); end
    if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack_async: got %b want 0", wr_ack); end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp += 3;
      if (wr_ack !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b want 0", wr_ack); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      if (q9 !== 9'h000) begin n_bad++; $display("FAIL abort_q9: got %h want 000", q9); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    logic [8:0] v;
    do_reset();
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      d = 4'(i % 10);
      v = 9'($urandom);
      wr_req = 1; dst = d; din = v;
      if (i % 3 == 0) model_req(d, v);
    end
    @(negedge clk);
    wr_req = 0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    n_cmp += 3;
    if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size()); end
    if (wr_cnt !== 8'd0) begin n_bad++; $display("FAIL b2b_wrap: got %0d want 0", wr_cnt); end
    if (qv !== m_pack()) begin n_bad++; $display("FAIL b2b_q: got %h want %h", qv, m_pack()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_invalid();
    test_all_regs();
    test_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
